// File: rtl/axis_hdr_pkg.sv
// Shared types and keep-mask helpers for the AXI-Stream header inserter.
// Masks are built at the maximum width and sized down at each use.
package axis_hdr_pkg;

  localparam int MAX_BYTES = 64;

  typedef logic [MAX_BYTES-1:0] kmask_t;
  typedef enum logic [1:0] {IDLE, STREAM, TAIL} state_t;

  function automatic int keep_count(input kmask_t k);
    int c;
    c = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (k[i]) c++;
    end
    return c;
  endfunction

  function automatic kmask_t lsb_mask(input int c);
    kmask_t m;
    for (int i = 0; i < MAX_BYTES; i++) m[i] = (i < c);
    return m;
  endfunction

  // c leading ones within an n-bit keep, i.e. the first c byte lanes
  function automatic kmask_t msb_mask(input int c, input int n);
    kmask_t m;
    for (int i = 0; i < MAX_BYTES; i++) m[i] = (i < n) && (i >= n - c);
    return m;
  endfunction

  function automatic logic lsb_contig(input kmask_t k);
    return (k != '0) && (k == lsb_mask(keep_count(k)));
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register slice: 1-cycle latency, full throughput.
// Backpressure: in_ready comes only from the skid register, never from in_valid.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             skid_vld;
  logic [WIDTH-1:0] skid_dat;

  assign in_ready = !skid_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_dat  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_vld) begin
        out_valid <= 1'b1;
        out_data  <= skid_dat;
        skid_vld  <= 1'b0;
      end else begin
        out_valid <= in_valid;
        out_data  <= in_valid ? in_data : '0;
      end
    end else if (in_valid && !skid_vld) begin
      skid_vld <= 1'b1;
      skid_dat <= in_data;
    end
  end

endmodule

// File: rtl/axis_hdr_insert_gen.sv
// Prepends a 1..N byte header to each packet and realigns the payload behind it.
// Latency 1 cycle through a skid slice; backpressure is ready/valid on all ports.
module axis_hdr_insert_gen
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert,
  output logic                    hdr_err
);

  localparam int N  = DATA_BYTE_WD;
  localparam int SW = DATA_WD + N + 1;

  typedef logic [BYTE_CNT_WD:0] cnt_t;

  function automatic logic [DATA_WD-1:0] lane_mask(input logic [N-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < N; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t             state;
  logic [DATA_WD-1:0] res;
  cnt_t               h_q;
  cnt_t               tail_q;
  logic               hdr_beat;

  logic               s_vld;
  logic               s_rdy;
  logic [DATA_WD-1:0] s_dat_raw;
  logic [N-1:0]       s_keep;
  logic               s_last;
  logic [N-1:0]       res_keep;
  logic               ins_bad;
  logic               pkt_done;
  int                 h_int;
  int                 k_int;
  int                 ins_cnt;

  always_comb begin
    h_int     = int'(h_q);
    k_int     = keep_count(kmask_t'(keep_in));
    ins_cnt   = keep_count(kmask_t'(keep_insert));
    ins_bad   = !lsb_contig(kmask_t'(keep_insert)) ||
                (((ins_cnt == N) ? 0 : ins_cnt) != int'(byte_insert_cnt));
    pkt_done  = (h_int == N) || (k_int <= N - h_int);
    res_keep  = N'(lsb_mask(h_int));
    ready_in  = (state == STREAM) && !hdr_beat && s_rdy && !rst;
    s_vld     = 1'b0;
    s_dat_raw = '0;
    s_keep    = '1;
    s_last    = 1'b0;
    case (state)
      STREAM: begin
        if (hdr_beat) begin
          // A full-width header goes out alone; payload then passes unshifted.
          s_vld     = 1'b1;
          s_dat_raw = res;
        end else begin
          s_vld     = valid_in;
          s_dat_raw = (h_int == N) ? data_in
                    : (res << (8 * (N - h_int))) | (data_in >> (8 * h_int));
          if (last_in) begin
            if (h_int == N) begin
              s_keep = keep_in;
              s_last = 1'b1;
            end else if (pkt_done) begin
              s_keep = N'(msb_mask(h_int + k_int, N));
              s_last = 1'b1;
            end
          end
        end
      end
      TAIL: begin
        s_vld     = 1'b1;
        s_dat_raw = res << (8 * (N - h_int));
        s_keep    = N'(msb_mask(int'(tail_q), N));
        s_last    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      res          <= '0;
      h_q          <= '0;
      tail_q       <= '0;
      hdr_beat     <= 1'b0;
      ready_insert <= 1'b0;
      hdr_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_insert <= 1'b1;
          if (valid_insert && ready_insert) begin
            res          <= data_insert & lane_mask(N'(lsb_mask(ins_cnt)));
            h_q          <= cnt_t'(ins_cnt);
            hdr_beat     <= (ins_cnt == N);
            ready_insert <= 1'b0;
            state        <= STREAM;
            if (ins_bad) hdr_err <= 1'b1;
          end
        end
        STREAM: begin
          if (hdr_beat) begin
            if (s_rdy) hdr_beat <= 1'b0;
          end else if (valid_in && ready_in) begin
            res <= data_in & lane_mask(res_keep);
            if (last_in) begin
              if (pkt_done) begin
                state        <= IDLE;
                ready_insert <= 1'b1;
              end else begin
                state  <= TAIL;
                tail_q <= cnt_t'(k_int - (N - h_int));
              end
            end
          end
        end
        TAIL: begin
          if (s_rdy) begin
            state        <= IDLE;
            ready_insert <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_skid_buf #(.WIDTH(SW)) u_out (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_vld),
    .in_data   ({s_last, s_keep, s_dat_raw & lane_mask(s_keep)}),
    .in_ready  (s_rdy),
    .out_valid (valid_out),
    .out_data  ({last_out, keep_out, data_out}),
    .out_ready (ready_out)
  );

endmodule

// File: tb/tb_axis_hdr_insert_gen.sv
// Bench for axis_hdr_insert_gen: directed packets plus randomized traffic
// compared against a byte-stream model of header||payload chopped into beats.
module tb_axis_hdr_insert_gen;

  localparam int DW = 32;
  localparam int N  = DW / 8;
  localparam int CW = $clog2(N);

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [N-1:0]  keep_in;
  logic          last_in;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [N-1:0]  keep_out;
  logic          last_out;
  logic          ready_out;
  logic          valid_insert;
  logic [DW-1:0] data_insert;
  logic [N-1:0]  keep_insert;
  logic [CW-1:0] byte_insert_cnt;
  logic          ready_insert;
  logic          hdr_err;

  int errors = 0;
  int checks = 0;
  int gap = 0;
  bit rand_rdy = 0;

  logic [8:0]    bq[$];
  logic [DW+N:0] obs[$];
  logic          exp_err = 0;
  logic          prev_stall = 0;
  logic [DW+N+1:0] prev_out = '0;

  axis_hdr_insert_gen #(.DATA_WD(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert),
    .hdr_err         (hdr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] lead_ones(input int c);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (i >= N - c);
    return m;
  endfunction

  function automatic logic [N-1:0] low_ones(input int c);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (i < c);
    return m;
  endfunction

  function automatic int ones(input logic [N-1:0] k);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (k[i]) c++;
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: every accepted header/payload byte is queued in wire order; the
  // last payload byte of a packet carries a flag. Each output beat must be
  // the next up-to-N bytes, stopping after a flagged byte.
  always @(negedge clk) begin : mon
    logic [DW-1:0] ed;
    logic [N-1:0]  ek;
    logic          el;
    logic [8:0]    b;
    int            c;
    int            h;
    int            k;
    if (rst) begin
      bq.delete();
      exp_err    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("hdr_err", 64'(hdr_err), 64'(exp_err));
      if (prev_stall)
        check("stall_hold", 64'({valid_out, last_out, keep_out, data_out}), 64'(prev_out));
      if (valid_out && ready_out) begin
        ed = '0;
        el = 1'b0;
        c  = 0;
        while (c < N && bq.size() > 0 && !el) begin
          b = bq.pop_front();
          ed[DW-1-8*c -: 8] = b[7:0];
          el = b[8];
          c++;
        end
        ek = lead_ones(c);
        check("beat", 64'({last_out, keep_out, data_out}), 64'({el, ek, ed}));
        obs.push_back({last_out, keep_out, data_out});
      end
      prev_stall = valid_out && !ready_out;
      prev_out   = {valid_out, last_out, keep_out, data_out};
      if (valid_insert && ready_insert) begin
        h = ones(keep_insert);
        for (int j = N - h; j < N; j++) bq.push_back({1'b0, data_insert[DW-1-8*j -: 8]});
        if (keep_insert != low_ones(h) || h == 0 || (h % N) != int'(byte_insert_cnt))
          exp_err = 1'b1;
      end
      if (valid_in && ready_in) begin
        k = ones(keep_in);
        for (int j = 0; j < k; j++)
          bq.push_back({last_in && (j == k - 1), data_in[DW-1-8*j -: 8]});
      end
    end
  end

  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic idle_gap();
    repeat ($urandom_range(0, gap)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_hdr(input logic [N-1:0] k, input logic [CW-1:0] cnt, input logic [DW-1:0] d);
    logic acc;
    idle_gap();
    valid_insert    = 1'b1;
    keep_insert     = k;
    byte_insert_cnt = cnt;
    data_insert     = d;
    do begin
      @(negedge clk);
      acc = ready_insert;
      @(posedge clk);
      #1;
    end while (!acc);
    valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
    logic acc;
    idle_gap();
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    do begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
    end while (!acc);
    valid_in = 1'b0;
  endtask

  task automatic send_payload(input int len);
    int nb;
    int k;
    nb = (len + N - 1) / N;
    for (int b = 0; b < nb; b++) begin
      k = (b == nb - 1) ? len - (nb - 1) * N : N;
      send_beat($urandom(), lead_ones(k), b == nb - 1);
    end
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic chk_obs(input string name, input int idx, input logic [DW+N:0] exp);
    logic [63:0] a;
    a = (idx < obs.size()) ? 64'(obs[idx]) : 64'hDEAD_DEAD_DEAD_DEAD;
    check(name, a, 64'(exp));
  endtask

  initial begin
    #400000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_keep_out", 64'(keep_out), 64'd0);
    check("rst_ready_insert", 64'(ready_insert), 64'd0);
    check("rst_ready_in", 64'(ready_in), 64'd0);
    rst = 1'b0;

    // H=3 with overflow into a tail beat
    obs.delete();
    send_hdr(4'b0111, 2'd3, 32'h00AABBCC);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b1);
    drain();
    check("t1_count", 64'(obs.size()), 64'd3);
    chk_obs("t1_b0", 0, {1'b0, 4'b1111, 32'hAABBCC11});
    chk_obs("t1_b1", 1, {1'b0, 4'b1111, 32'h22334455});
    chk_obs("t1_b2", 2, {1'b1, 4'b1110, 32'h66778800});

    // H=2, short last beat fits: no tail; garbage lanes must be zeroed
    obs.delete();
    send_hdr(4'b0011, 2'd2, 32'h0000A1A2);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05FFFFFF, 4'b1000, 1'b1);
    drain();
    check("t2_count", 64'(obs.size()), 64'd2);
    chk_obs("t2_b0", 0, {1'b0, 4'b1111, 32'hA1A20102});
    chk_obs("t2_b1", 1, {1'b1, 4'b1110, 32'h03040500});

    // H=N: header alone, payload unshifted
    obs.delete();
    send_hdr(4'b1111, 2'd0, 32'hCAFEF00D);
    send_beat(32'hDEADBEEF, 4'b1100, 1'b1);
    drain();
    check("t3_count", 64'(obs.size()), 64'd2);
    chk_obs("t3_b0", 0, {1'b0, 4'b1111, 32'hCAFEF00D});
    chk_obs("t3_b1", 1, {1'b1, 4'b1100, 32'hDEAD0000});

    // Randomized traffic with downstream stalls
    rand_rdy = 1;
    gap = 2;
    fork
      begin : hdrs
        int h;
        for (int p = 0; p < 200; p++) begin
          h = $urandom_range(1, N);
          send_hdr(low_ones(h), CW'(h % N), $urandom());
        end
      end
      begin : pays
        for (int p = 0; p < 200; p++) send_payload($urandom_range(1, 3 * N));
      end
    join
    rand_rdy = 0;
    gap = 0;
    for (int i = 0; i < 300; i++) begin
      if (bq.size() == 0 && !valid_out) break;
      @(posedge clk);
      #1;
    end
    check("t4_drained", 64'(bq.size()), 64'd0);

    // Count mismatch flags the error but the header still uses H=2
    obs.delete();
    send_hdr(4'b0011, 2'd1, 32'h0000B1B2);
    check("t5_err_set", 64'(hdr_err), 64'd1);
    send_beat(32'h0A0B0C0D, 4'b1111, 1'b1);
    drain();
    check("t5_b_count", 64'(obs.size()), 64'd2);
    chk_obs("t5_b0", 0, {1'b0, 4'b1111, 32'hB1B20A0B});
    chk_obs("t5_b1", 1, {1'b1, 4'b1100, 32'h0C0D0000});
    check("t5_err_sticky", 64'(hdr_err), 64'd1);

    // Reset mid-packet, then a clean packet with no stale residual
    send_hdr(4'b0001, 2'd1, 32'h000000EE);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_outs", 64'({valid_out, last_out, keep_out, data_out}), 64'd0);
    check("t6_rst_rdys", 64'({ready_in, ready_insert, hdr_err}), 64'd0);
    rst = 1'b0;
    obs.delete();
    send_hdr(4'b0111, 2'd3, 32'h00C1C2C3);
    send_beat(32'h10203040, 4'b1111, 1'b1);
    drain();
    check("t6_count", 64'(obs.size()), 64'd2);
    chk_obs("t6_b0", 0, {1'b0, 4'b1111, 32'hC1C2C310});
    chk_obs("t6_b1", 1, {1'b1, 4'b1110, 32'h20304000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
